// File: rtl/lut_layer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// lut_seq_pkg
// Shared types and constants for the time-multiplexed LUT layer sequencer.
//   state_t        : sequencer FSM states (IDLE, EVAL, HOLD)
//   CFG_SEL_*      : cfg_sel encodings (connectivity table / truth table)
//   DEF_*          : default layer geometry
//   TBL_DEPTH      : truth-table entries per neuron for the default FANIN
//   tbl_depth()    : truth-table entries per neuron for an arbitrary FANIN
// -----------------------------------------------------------------------------
package lut_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      HOLD
   } state_t;

   localparam logic CFG_SEL_CONN  = 1'b0;
   localparam logic CFG_SEL_TABLE = 1'b1;

   localparam int unsigned DEF_IN_WIDTH    = 64;
   localparam int unsigned DEF_NUM_NEURONS = 16;
   localparam int unsigned DEF_FANIN       = 6;

   localparam int unsigned TBL_DEPTH = 2 ** DEF_FANIN;

   function automatic int unsigned tbl_depth(input int unsigned fanin);
      return 32'd1 << fanin;
   endfunction

endpackage

// File: rtl/lut_layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// lut_layer_sequencer_if
// Bundles the config port, input-vector handshake, result handshake and status
// of the LUT layer sequencer.
//   cfg_we/cfg_sel/cfg_addr/cfg_wdata : table write port (cfg_err: sticky drop)
//   in_valid/in_ready/in_data         : activation vector handshake
//   out_valid/out_ready/out_data      : layer result handshake
//   busy                              : sequencer is not idle
// Modports: master = producer/consumer side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface lut_layer_sequencer_if
   import lut_seq_pkg::*;
#(
   parameter int unsigned IN_WIDTH    = DEF_IN_WIDTH,
   parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int unsigned FANIN       = DEF_FANIN,
   parameter int unsigned IDX_W       = $clog2(IN_WIDTH),
   parameter int unsigned CA_W        = $clog2(NUM_NEURONS * (2 ** FANIN))
);

   logic                   cfg_we;
   logic                   cfg_sel;
   logic [CA_W-1:0]        cfg_addr;
   logic [IDX_W-1:0]       cfg_wdata;
   logic                   cfg_err;
   logic                   in_valid;
   logic                   in_ready;
   logic [IN_WIDTH-1:0]    in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [NUM_NEURONS-1:0] out_data;
   logic                   busy;

   modport master (
      output cfg_we, cfg_sel, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
      input  cfg_err, in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  cfg_we, cfg_sel, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
      output cfg_err, in_ready, out_valid, out_data, busy
   );

endinterface

// File: rtl/lut_layer_sequencer_fanin_gather.sv
// -----------------------------------------------------------------------------
// lut_fanin_gather
// Combinational FANIN-way index mux: picks FANIN bits out of the latched input
// vector using the connectivity indices of the neuron being evaluated.
//   latched_in : activation vector captured at the input handshake
//   conn_sel   : FANIN fan-in indices of the current neuron
//   addr       : truth-table address, fan-in k drives bit k
// An index >= IN_WIDTH selects a constant 0.
// -----------------------------------------------------------------------------
module lut_fanin_gather
   import lut_seq_pkg::*;
#(
   parameter int unsigned IN_WIDTH = DEF_IN_WIDTH,
   parameter int unsigned FANIN    = DEF_FANIN,
   parameter int unsigned IDX_W    = $clog2(IN_WIDTH)
) (
   input  logic [IN_WIDTH-1:0]          latched_in,
   input  logic [FANIN-1:0][IDX_W-1:0]  conn_sel,
   output logic [FANIN-1:0]             addr
);

   // Zero-padding the vector out to the full index range makes every
   // out-of-range index land on a 0 bit without a compare per fan-in.
   localparam int unsigned PAD_W = 32'd1 << IDX_W;

   logic [PAD_W-1:0] padded;

   always_comb begin
      padded                 = '0;
      padded[IN_WIDTH-1:0]   = latched_in;
      addr                   = '0;
      for (int unsigned k = 0; k < FANIN; k++) begin
         addr[k] = padded[conn_sel[k]];
      end
   end

endmodule

// File: rtl/lut_layer_sequencer.sv
// -----------------------------------------------------------------------------
// lut_layer_sequencer
// Time-multiplexed evaluator for one layer of FANIN-input, 1-bit LUT neurons.
// One gather + truth-table lookup path is shared by all NUM_NEURONS neurons;
// one neuron is evaluated per cycle.
//   clk, rst : clock, asynchronous active-high reset (clears all tables)
//   bus      : lut_layer_sequencer_if.slave (config, input, output, status)
// Build option: define LUT_PIPE_EN to register the gathered address and neuron
// index before the table read (one extra EVAL cycle).
// -----------------------------------------------------------------------------
module lut_layer_sequencer
   import lut_seq_pkg::*;
#(
   parameter int unsigned IN_WIDTH    = DEF_IN_WIDTH,
   parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int unsigned FANIN       = DEF_FANIN,
   parameter int unsigned IDX_W       = $clog2(IN_WIDTH),
   parameter int unsigned CA_W        = $clog2(NUM_NEURONS * (2 ** FANIN))
) (
   input logic                  clk,
   input logic                  rst,
   lut_layer_sequencer_if.slave bus
);

   localparam int unsigned TBL      = tbl_depth(FANIN);
   localparam int unsigned CONN_N   = NUM_NEURONS * FANIN;
   localparam int unsigned CONN_AW  = $clog2(CONN_N);
   localparam int unsigned NI_W     = $clog2(NUM_NEURONS);
   localparam int unsigned NC_W     = $clog2(NUM_NEURONS + 1);
   localparam int unsigned TBL_BITS = 32'd1 << CA_W;

   state_t                  state_q, state_d;
   logic [NC_W-1:0]         n_q, n_d;
   logic [IN_WIDTH-1:0]     in_q, in_d;
   logic [IDX_W-1:0]        conn_q [CONN_N];
   logic [IDX_W-1:0]        conn_d [CONN_N];
   logic [TBL_BITS-1:0]     tbl_q, tbl_d;
   logic [NUM_NEURONS-1:0]  out_data_q, out_data_d;
   logic                    cfg_err_q, cfg_err_d;

`ifdef LUT_PIPE_EN
   logic                    pipe_vld_q, pipe_vld_d;
   logic [FANIN-1:0]        pipe_addr_q, pipe_addr_d;
   logic [NI_W-1:0]         pipe_n_q, pipe_n_d;
`endif

   logic [NI_W-1:0]              n_sel;
   logic [FANIN-1:0][IDX_W-1:0]  gather_conn;
   logic [FANIN-1:0]             gather_addr;

   assign n_sel = n_q[NI_W-1:0];

   // Connectivity row of the neuron currently being gathered.
   always_comb begin
      gather_conn = '0;
      for (int unsigned k = 0; k < FANIN; k++) begin
         gather_conn[k] = conn_q[CONN_AW'(32'(n_sel) * FANIN + k)];
      end
   end

   lut_fanin_gather #(
      .IN_WIDTH (IN_WIDTH),
      .FANIN    (FANIN),
      .IDX_W    (IDX_W)
   ) u_gather (
      .latched_in (in_q),
      .conn_sel   (gather_conn),
      .addr       (gather_addr)
   );

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      in_d       = in_q;
      conn_d     = conn_q;
      tbl_d      = tbl_q;
      out_data_d = out_data_q;
      cfg_err_d  = cfg_err_q;
`ifdef LUT_PIPE_EN
      pipe_vld_d  = 1'b0;
      pipe_addr_d = pipe_addr_q;
      pipe_n_d    = pipe_n_q;
`endif

      // Config port: writes land only in IDLE; anything else is dropped and
      // flagged. Tables are never read in IDLE, so no read/write overlap.
      if (bus.cfg_we) begin
         if (state_q != IDLE) begin
            cfg_err_d = 1'b1;
         end else if (bus.cfg_sel == CFG_SEL_CONN) begin
            if (bus.cfg_addr < CA_W'(CONN_N)) begin
               conn_d[CONN_AW'(bus.cfg_addr)] = bus.cfg_wdata;
            end else begin
               cfg_err_d = 1'b1;
            end
         end else begin
            tbl_d[bus.cfg_addr] = bus.cfg_wdata[0];
         end
      end

      unique case (state_q)
         IDLE: begin
            // A concurrent config write takes priority over a new vector.
            if (bus.in_valid && !bus.cfg_we) begin
               in_d    = bus.in_data;
               n_d     = '0;
               state_d = EVAL;
            end
         end
         EVAL: begin
`ifdef LUT_PIPE_EN
            // Issue stage keeps gathering until all neurons are in flight;
            // HOLD is entered once the last neuron drains out of the read stage.
            if (n_q < NC_W'(NUM_NEURONS)) begin
               pipe_vld_d  = 1'b1;
               pipe_addr_d = gather_addr;
               pipe_n_d    = n_sel;
               n_d         = n_q + NC_W'(1);
            end
            if (pipe_vld_q) begin
               out_data_d[pipe_n_q] = tbl_q[{pipe_n_q, pipe_addr_q}];
               if (pipe_n_q == NI_W'(NUM_NEURONS - 1)) begin
                  state_d = HOLD;
               end
            end
`else
            // Per-neuron tables are 2**FANIN deep, so {n, addr} == n*TBL+addr.
            out_data_d[n_sel] = tbl_q[{n_sel, gather_addr}];
            n_d               = n_q + NC_W'(1);
            if (n_q == NC_W'(NUM_NEURONS - 1)) begin
               state_d = HOLD;
            end
`endif
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         in_q       <= '0;
         conn_q     <= '{default: '0};
         tbl_q      <= '0;
         out_data_q <= '0;
         cfg_err_q  <= 1'b0;
`ifdef LUT_PIPE_EN
         pipe_vld_q  <= 1'b0;
         pipe_addr_q <= '0;
         pipe_n_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         in_q       <= in_d;
         conn_q     <= conn_d;
         tbl_q      <= tbl_d;
         out_data_q <= out_data_d;
         cfg_err_q  <= cfg_err_d;
`ifdef LUT_PIPE_EN
         pipe_vld_q  <= pipe_vld_d;
         pipe_addr_q <= pipe_addr_d;
         pipe_n_q    <= pipe_n_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && !bus.cfg_we;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_data  = out_data_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lut_layer_sequencer
// Directed self-checking bench for lut_layer_sequencer (default geometry:
// 64-bit input, 16 neurons, fan-in 6). Expected values are hand-derived from
// the configured tables.
// -----------------------------------------------------------------------------
module tb_lut_layer_sequencer;
   import lut_seq_pkg::*;

   localparam int unsigned IN_WIDTH    = 64;
   localparam int unsigned NUM_NEURONS = 16;
   localparam int unsigned FANIN       = 6;
   localparam int unsigned IDX_W       = 6;
   localparam int unsigned CA_W        = 10;
   localparam int unsigned TBL         = 64;
`ifdef LUT_PIPE_EN
   localparam int unsigned EXP_LAT = NUM_NEURONS + 2;
`else
   localparam int unsigned EXP_LAT = NUM_NEURONS + 1;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lut_layer_sequencer_if #(
      .IN_WIDTH    (IN_WIDTH),
      .NUM_NEURONS (NUM_NEURONS),
      .FANIN       (FANIN),
      .IDX_W       (IDX_W),
      .CA_W        (CA_W)
   ) bus_if ();

   lut_layer_sequencer #(
      .IN_WIDTH    (IN_WIDTH),
      .NUM_NEURONS (NUM_NEURONS),
      .FANIN       (FANIN),
      .IDX_W       (IDX_W),
      .CA_W        (CA_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic sel, input int unsigned addr, input int unsigned data);
      bus_if.cfg_we    = 1'b1;
      bus_if.cfg_sel   = sel;
      bus_if.cfg_addr  = CA_W'(addr);
      bus_if.cfg_wdata = IDX_W'(data);
      tick();
      bus_if.cfg_we    = 1'b0;
   endtask

   // Returns one cycle after the input handshake edge (cycle 1).
   task automatic start_vec(input logic [63:0] d);
      int waited;
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = d;
      #1;
      waited = 0;
      while (!bus_if.in_ready && waited < 50) begin
         tick();
         waited++;
      end
      if (waited >= 50) check_eq("accept_timeout", 64'(bus_if.in_ready), 64'd1);
      tick();
      bus_if.in_valid = 1'b0;
   endtask

   // lat counts the cycle index at which out_valid is first seen.
   task automatic wait_out(output int lat);
      lat = 1;
      while (!bus_if.out_valid && lat < 64) begin
         tick();
         lat++;
      end
      check_eq("out_valid_seen", 64'(bus_if.out_valid), 64'd1);
   endtask

   task automatic run_vec(input string tag, input logic [63:0] d, input logic [15:0] exp);
      int lat;
      start_vec(d);
      wait_out(lat);
      check_eq({tag, "_lat"}, 64'(lat), 64'(EXP_LAT));
      check_eq({tag, "_data"}, 64'(bus_if.out_data), 64'(exp));
      check_eq({tag, "_hold_ready"}, 64'(bus_if.in_ready), 64'd0);
      tick();
      check_eq({tag, "_ready_after"}, 64'(bus_if.in_ready), 64'd1);
      check_eq({tag, "_busy_after"}, 64'(bus_if.busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat;
      rst              = 1'b1;
      bus_if.cfg_we    = 1'b0;
      bus_if.cfg_sel   = 1'b0;
      bus_if.cfg_addr  = '0;
      bus_if.cfg_wdata = '0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = '0;
      bus_if.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
      check_eq("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      check_eq("rst_out_data", 64'(bus_if.out_data), 64'd0);
      check_eq("rst_busy", 64'(bus_if.busy), 64'd0);
      check_eq("rst_cfg_err", 64'(bus_if.cfg_err), 64'd0);
      rst = 1'b0;
      tick();

      // Identity: every fan-in of neuron n reads input bit n; only entry 63 set.
      for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
         for (int unsigned k = 0; k < FANIN; k++) cfg_write(CFG_SEL_CONN, n * FANIN + k, n);
         cfg_write(CFG_SEL_TABLE, n * TBL + 63, 1);
      end
      run_vec("ident_ones", '1, 16'hFFFF);
      run_vec("ident_zero", 64'h0, 16'h0000);

      // Address ordering on neuron 0: fan-in k -> input bit k, only entry 3 set.
      for (int unsigned k = 0; k < FANIN; k++) cfg_write(CFG_SEL_CONN, k, k);
      cfg_write(CFG_SEL_TABLE, 63, 0);
      cfg_write(CFG_SEL_TABLE, 3, 1);
      run_vec("ord_3", 64'h3, 16'h0003);   // n0: addr 3; n1: bit1 set
      run_vec("ord_5", 64'h5, 16'h0004);   // n0: addr 5 -> 0; n2: bit2 set

      // Backpressure in HOLD, with a competing vector offered.
      bus_if.out_ready = 1'b0;
      start_vec(64'h3);
      wait_out(lat);
      check_eq("bp_lat", 64'(lat), 64'(EXP_LAT));
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = '1;
      for (int i = 0; i < 10; i++) begin
         check_eq("bp_out_valid", 64'(bus_if.out_valid), 64'd1);
         check_eq("bp_out_data", 64'(bus_if.out_data), 64'h0003);
         check_eq("bp_in_ready", 64'(bus_if.in_ready), 64'd0);
         tick();
      end
      bus_if.out_ready = 1'b1;
      check_eq("bp_release_ready", 64'(bus_if.in_ready), 64'd0);
      tick();
      check_eq("bp_ready_after", 64'(bus_if.in_ready), 64'd1);
      tick();
      bus_if.in_valid = 1'b0;
      wait_out(lat);
      check_eq("bp_second_lat", 64'(lat), 64'(EXP_LAT));
      check_eq("bp_second_data", 64'(bus_if.out_data), 64'hFFFE);
      tick();

      // Config write during EVAL is dropped and flagged.
      start_vec(64'h3);
      tick();
      tick();
      cfg_write(CFG_SEL_TABLE, 63, 1);
      check_eq("eval_cfg_err", 64'(bus_if.cfg_err), 64'd1);
      wait_out(lat);
      check_eq("eval_cfg_data", 64'(bus_if.out_data), 64'h0003);
      tick();
      run_vec("after_drop", '1, 16'hFFFE);
      check_eq("cfg_err_sticky", 64'(bus_if.cfg_err), 64'd1);

      // Simultaneous config write and vector: write wins, vector next cycle.
      bus_if.cfg_we    = 1'b1;
      bus_if.cfg_sel   = CFG_SEL_TABLE;
      bus_if.cfg_addr  = CA_W'(5);
      bus_if.cfg_wdata = IDX_W'(1);
      bus_if.in_valid  = 1'b1;
      bus_if.in_data   = 64'h5;
      #1;
      check_eq("sim_in_ready_low", 64'(bus_if.in_ready), 64'd0);
      tick();
      bus_if.cfg_we = 1'b0;
      #1;
      check_eq("sim_busy_idle", 64'(bus_if.busy), 64'd0);
      check_eq("sim_in_ready_high", 64'(bus_if.in_ready), 64'd1);
      tick();
      bus_if.in_valid = 1'b0;
      wait_out(lat);
      check_eq("sim_lat", 64'(lat), 64'(EXP_LAT));
      check_eq("sim_data", 64'(bus_if.out_data), 64'h0005);
      tick();

      // Reset in the middle of EVAL (neuron 7).
      start_vec('1);
      repeat (7) tick();
      check_eq("mid_busy", 64'(bus_if.busy), 64'd1);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_out_valid", 64'(bus_if.out_valid), 64'd0);
      check_eq("mid_rst_busy", 64'(bus_if.busy), 64'd0);
      check_eq("mid_rst_cfg_err", 64'(bus_if.cfg_err), 64'd0);
      check_eq("mid_rst_out_data", 64'(bus_if.out_data), 64'd0);
      check_eq("mid_rst_in_ready", 64'(bus_if.in_ready), 64'd1);
      tick();
      rst = 1'b0;
      tick();
      run_vec("post_rst", '1, 16'h0000);

      // Connectivity address beyond NUM_NEURONS*FANIN is dropped and flagged.
      cfg_write(CFG_SEL_CONN, NUM_NEURONS * FANIN, 0);
      check_eq("conn_oor_err", 64'(bus_if.cfg_err), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
